// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-granular arbiter that shares one UART transmitter input
// between NUM_REQ byte-stream requesters so messages are never interleaved.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_BURST = 16,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [OW-1:0]        owner,
  output logic                 busy,
  output logic                 state_dbg
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state;
  logic [7:0]    burst_cnt;
  logic [OW-1:0] ptr;
  logic [OW-1:0] pick;
  logic [OW-1:0] ptr_next;
  logic          found;
  logic [7:0]    req_bytes [NUM_REQ];
  logic [7:0]    sel_byte;
  logic          sel_last;
  logic          accept;
  logic          burst_at_max;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // First valid requester at or above ptr, else the first valid one below it.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (OW'(i) >= ptr)) begin
        pick  = OW'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        pick  = OW'(i);
        found = 1'b1;
      end
    end
  end

  // Valid/ready: a byte moves on any clk edge where valid and ready are both
  // high; the sender holds data/valid/last stable until that edge. The output
  // register is one entry, so the owner may refill it in the cycle it drains.
  always_comb begin
    req_ready = '0;
    if (state == GRANT) req_ready[owner] = !tx_valid || tx_ready;
  end

  assign sel_byte     = req_bytes[owner];
  assign sel_last     = req_last[owner];
  assign accept       = (state == GRANT) && req_valid[owner] && req_ready[owner];
  assign burst_at_max = (burst_cnt == 8'(MAX_BURST - 1));
  assign ptr_next     = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
  assign busy         = (state == GRANT) || tx_valid;
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      ptr       <= '0;
    end else begin
      if (accept) begin
        tx_data  <= sel_byte;
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|req_valid) begin
            owner     <= pick;
            burst_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // Grant is held indefinitely if the owner stalls; only accepted bytes count.
          if (accept) begin
            burst_cnt <= burst_cnt + 8'd1;
            if (sel_last || burst_at_max) begin
              state <= IDLE;
              ptr   <= ptr_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues feed the DUT, a
// scoreboard checks every byte leaving on tx_* against an expected order.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int MAX_BURST = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [0:0]           owner;
  logic                 busy;
  logic                 state_dbg;

  int checks = 0;
  int errors = 0;

  logic [8:0] src_q [NUM_REQ][$];
  logic [7:0] exp_q [$];

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .owner(owner), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    tx_ready = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) src_q[r].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // drivers
  task automatic drive_requesters();
    logic [NUM_REQ-1:0] fire;
    logic [8:0] head;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      fire = req_valid & req_ready & {NUM_REQ{!rst}};
      @(posedge clk); #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (fire[r] && src_q[r].size() > 0) head = src_q[r].pop_front();
        if (src_q[r].size() > 0) begin
          head = src_q[r][0];
          req_valid[r] = 1'b1;
          req_data[r*8 +: 8] = head[7:0];
          req_last[r] = head[8];
        end else begin
          req_valid[r] = 1'b0;
          req_last[r] = 1'b0;
        end
      end
    end
  endtask

  task automatic push_src(input int r, input logic [7:0] d, input logic last);
    src_q[r].push_back({last, d});
  endtask

  // scoreboard
  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_byte: got unexpected 0x%02h, expected no byte", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            errors++;
            $display("FAIL tx_byte: got 0x%02h, expected 0x%02h", tx_data, e);
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input int max_cycles, output bit ok);
    int pending;
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      pending = exp_q.size();
      for (int r = 0; r < NUM_REQ; r++) pending += src_q[r].size();
      if (pending == 0 && !tx_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b, expected 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got 0x%02h, expected 0x00", tx_data); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b, expected 00", req_ready); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %0d, expected 0", owner); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state: got %b, expected 0", state_dbg); end
  endtask

  task automatic test_single();
    bit ok;
    apply_reset();
    @(negedge clk);
    push_src(0, 8'h61, 1'b0); push_src(0, 8'h62, 1'b0); push_src(0, 8'h63, 1'b1);
    exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h63);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_pre: got %b, expected 0", busy); end
    @(negedge clk);
    checks++; if (state_dbg !== 1'b1) begin errors++; $display("FAIL single_grant: got %b, expected 1", state_dbg); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b, expected 01", req_ready); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL single_lat: got %b, expected 0", tx_valid); end
    @(negedge clk);
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h61}) begin errors++; $display("FAIL single_b0: got %b/0x%02h, expected 1/0x61", tx_valid, tx_data); end
    @(negedge clk);
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h62}) begin errors++; $display("FAIL single_b1: got %b/0x%02h, expected 1/0x62", tx_valid, tx_data); end
    @(negedge clk);
    checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h63}) begin errors++; $display("FAIL single_b2: got %b/0x%02h, expected 1/0x63", tx_valid, tx_data); end
    checks++; if (state_dbg !== 1'b0) begin errors++; $display("FAIL single_release: got %b, expected 0", state_dbg); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL single_owner: got %0d, expected 0", owner); end
    @(negedge clk);
    checks++; if ({tx_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_drain: got valid/busy %b, expected 00", {tx_valid, busy}); end
    wait_idle(50, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_done: got timeout, expected all bytes sent"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    apply_reset();
    @(negedge clk);
    push_src(0, "a", 1'b0); push_src(0, "b", 1'b1); push_src(0, "c", 1'b0); push_src(0, "d", 1'b1);
    push_src(1, "x", 1'b0); push_src(1, "y", 1'b1); push_src(1, "z", 1'b0); push_src(1, "w", 1'b1);
    exp_q.push_back("a"); exp_q.push_back("b"); exp_q.push_back("x"); exp_q.push_back("y");
    exp_q.push_back("c"); exp_q.push_back("d"); exp_q.push_back("z"); exp_q.push_back("w");
    wait_idle(100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL two_done: got timeout, %0d bytes outstanding", exp_q.size()); end
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL two_last_owner: got %0d, expected 1", owner); end
  endtask

  task automatic test_max_burst();
    bit ok;
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < 20; i++) push_src(1, 8'h80 + 8'(i), 1'b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h80 + 8'(i));
    exp_q.push_back("m"); exp_q.push_back("n");
    for (int i = 16; i < 20; i++) exp_q.push_back(8'h80 + 8'(i));
    repeat (3) @(negedge clk);
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL burst_owner1: got %0d, expected 1", owner); end
    push_src(0, "m", 1'b0); push_src(0, "n", 1'b1);
    wait_idle(200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL burst_done: got timeout, %0d bytes outstanding", exp_q.size()); end
    // req1 stopped without a last byte: grant must still be held
    checks++; if ({state_dbg, owner, busy} !== 3'b111) begin errors++; $display("FAIL burst_hold: got state/owner/busy %b, expected 111", {state_dbg, owner, busy}); end
  endtask

  task automatic test_stall();
    bit ok;
    apply_reset();
    tx_ready = 1'b0;
    @(negedge clk);
    push_src(0, 8'h55, 1'b0); push_src(0, 8'h56, 1'b1);
    exp_q.push_back(8'h55); exp_q.push_back(8'h56);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid) begin ok = 1'b1; break; end
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_start: got tx_valid timeout, expected 1"); end
    for (int i = 0; i < 50; i++) begin
      checks++; if ({tx_valid, tx_data} !== {1'b1, 8'h55}) begin errors++; $display("FAIL stall_hold: got %b/0x%02h, expected 1/0x55", tx_valid, tx_data); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stall_ready: got %b, expected 00", req_ready); end
      @(negedge clk);
    end
    @(posedge clk); #1 tx_ready = 1'b1;
    wait_idle(50, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_done: got timeout, %0d bytes outstanding", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      push_src(1, 8'hA1 + 8'(i), (i == 4));
      exp_q.push_back(8'hA1 + 8'(i));
    end
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tx_valid) begin ok = 1'b1; break; end
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_start: got tx_valid timeout, expected 1"); end
    @(posedge clk); #1;
    rst = 1'b1;
    src_q[1].delete();
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid: got %b, expected 0", tx_valid); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mid_req_ready: got %b, expected 00", req_ready); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL mid_owner: got %0d, expected 0", owner); end
    checks++; if ({state_dbg, busy} !== 2'b00) begin errors++; $display("FAIL mid_state: got state/busy %b, expected 00", {state_dbg, busy}); end
    push_src(1, 8'hB1, 1'b0); push_src(1, 8'hB2, 1'b0); push_src(1, 8'hB3, 1'b1);
    exp_q.push_back(8'hB1); exp_q.push_back(8'hB2); exp_q.push_back(8'hB3);
    wait_idle(50, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_fresh: got timeout, %0d bytes outstanding", exp_q.size()); end
    checks++; if ({state_dbg, busy} !== 2'b00) begin errors++; $display("FAIL mid_final_idle: got state/busy %b, expected 00", {state_dbg, busy}); end
  endtask

  initial begin
    rst = 1'b1;
    tx_ready = 1'b1;
    fork
      drive_requesters();
      monitor();
    join_none
    test_reset();
    test_single();
    test_back_to_back();
    test_max_burst();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
